// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types for the TX DMA: endpoint address map, the bus word type,
// the DMA state encoding and the command bounds check.
package chiplet_types_pkg;

  typedef logic [31:0] word_t;

  // Endpoint register map seen by the DMA master port.
  localparam word_t TX_SEND_ADDR        = 32'h0000_1004;
  localparam word_t TX_CACHE_START_ADDR = 32'h0000_2000;
  localparam word_t TX_PTR_BASE_ADDR    = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    WR_CACHE,
    WR_PTR,
    WR_SEND,
    DONE,
    ERR
  } dma_state_t;

  // A command is usable only if it moves at least one word and the last word
  // still lands inside the TX cache.
  function automatic logic cmd_fits(input logic [6:0]  word_offset,
                                    input logic [7:0]  len,
                                    input int unsigned depth);
    logic [31:0] end_word;
    end_word = 32'(word_offset) + 32'(len);
    return (len != 8'd0) && (end_word <= depth);
  endfunction

endpackage

// File: rtl/dma_bus_master.sv
// Single-access bus handshake: the request is presented on the bus for as long
// as the owner asks for it, and completes in the first cycle the slave does not
// stall. Used once for the host memory read port and once for the endpoint port.
module dma_bus_master
  import chiplet_types_pkg::*;
(
  input  logic  req,
  input  word_t req_addr,
  input  logic  bus_stall,
  input  logic  bus_error,
  output logic  bus_en,
  output word_t bus_addr,
  output logic  ack,
  output logic  fault
);

  // Drive the bus only while requested; address is zeroed when idle so the
  // port is quiet outside an access.
  always_comb begin
    bus_en   = req;
    bus_addr = req ? req_addr : '0;
    ack      = req & ~bus_stall;
    fault    = req & ~bus_stall & bus_error;
  end

endmodule

// File: rtl/endpoint_tx_dma.sv
// Endpoint TX DMA: copies cmd_len words from host memory into the endpoint TX
// cache, writes the message pointer for cmd_msg_id and, when built with
// TX_DMA_AUTOSEND_EN, kicks the send register for that message.
module endpoint_tx_dma
  import chiplet_types_pkg::*;
#(
  parameter int NUM_MSGS        = 4,
  parameter int CACHE_NUM_WORDS = 128,
  localparam int MSG_W          = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
  input  logic             clk,
  input  logic             n_rst,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src_addr,
  input  logic [7:0]       cmd_len,
  input  logic [8:0]       cmd_offset,
  input  logic [MSG_W-1:0] cmd_msg_id,

  output logic             mem_ren,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_request_stall,

  output logic             ep_wen,
  output logic             ep_ren,
  output logic [31:0]      ep_addr,
  output logic [31:0]      ep_wdata,
  output logic [3:0]       ep_strobe,
  input  logic             ep_error,
  input  logic             ep_request_stall,

  output logic             busy,
  output logic             done,
  output logic             err
);

  dma_state_t       state_q;
  dma_state_t       state_d;

  word_t            src_q;
  logic [7:0]       len_q;
  logic [8:0]       offset_q;
  logic [MSG_W-1:0] msg_id_q;
  logic [7:0]       idx_q;
  word_t            data_q;

  logic             cmd_accept;
  logic             last_word;
  logic             mem_req;
  logic             ep_req;
  word_t            mem_req_addr;
  word_t            ep_req_addr;
  word_t            ep_req_data;
  logic             mem_ack;
  logic             mem_fault;
  logic             ep_ack;
  logic             ep_fault;

  // Word index arithmetic shared by the read address, the cache address and the
  // end-of-message test.
  always_comb begin
    mem_req_addr = src_q + 32'({idx_q, 2'b00});
    last_word    = ({1'b0, idx_q} + 9'd1) == {1'b0, len_q};
    cmd_accept   = cmd_valid & cmd_ready;
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode: each access state holds its request until
  // the owning port acknowledges, and an endpoint error on a completed write
  // aborts the whole transfer.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    mem_req     = 1'b0;
    ep_req      = 1'b0;
    ep_req_addr = '0;
    ep_req_data = '0;

    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = ~n_rst;
        if (cmd_valid && cmd_ready) begin
          state_d = cmd_fits(cmd_offset[8:2], cmd_len, CACHE_NUM_WORDS) ? RD_MEM : ERR;
        end
      end

      RD_MEM: begin
        mem_req = 1'b1;
        if (mem_fault) begin
          state_d = ERR;
        end else if (mem_ack) begin
          state_d = WR_CACHE;
        end
      end

      WR_CACHE: begin
        ep_req      = 1'b1;
        ep_req_addr = TX_CACHE_START_ADDR + 32'(offset_q) + 32'({idx_q, 2'b00});
        ep_req_data = data_q;
        if (ep_fault) begin
          state_d = ERR;
        end else if (ep_ack) begin
          state_d = last_word ? WR_PTR : RD_MEM;
        end
      end

      WR_PTR: begin
        ep_req      = 1'b1;
        ep_req_addr = TX_PTR_BASE_ADDR + 32'({msg_id_q, 2'b00});
        ep_req_data = 32'(offset_q);
        if (ep_fault) begin
          state_d = ERR;
        end else if (ep_ack) begin
`ifdef TX_DMA_AUTOSEND_EN
          state_d = WR_SEND;
`else
          state_d = DONE;
`endif
        end
      end

      WR_SEND: begin
`ifdef TX_DMA_AUTOSEND_EN
        ep_req      = 1'b1;
        ep_req_addr = TX_SEND_ADDR;
        ep_req_data = 32'(msg_id_q);
        if (ep_fault) begin
          state_d = ERR;
        end else if (ep_ack) begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch, word index and captured read data. Address low bits are
  // masked off so misaligned commands behave as their aligned equivalents.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      src_q    <= '0;
      len_q    <= '0;
      offset_q <= '0;
      msg_id_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      if (cmd_accept) begin
        src_q    <= cmd_src_addr & 32'hFFFF_FFFC;
        len_q    <= cmd_len;
        offset_q <= cmd_offset & 9'h1FC;
        msg_id_q <= cmd_msg_id;
        idx_q    <= '0;
      end
      if (state_q == RD_MEM && mem_ack) begin
        data_q <= mem_rdata;
      end
      if (state_q == WR_CACHE && ep_ack && !ep_fault && !last_word) begin
        idx_q <= idx_q + 8'd1;
      end
    end
  end

  // Host memory has no error signal, so its fault output only ever mirrors 0.
  dma_bus_master u_mem_port (
    .req       (mem_req),
    .req_addr  (mem_req_addr),
    .bus_stall (mem_request_stall),
    .bus_error (1'b0),
    .bus_en    (mem_ren),
    .bus_addr  (mem_addr),
    .ack       (mem_ack),
    .fault     (mem_fault)
  );

  dma_bus_master u_ep_port (
    .req       (ep_req),
    .req_addr  (ep_req_addr),
    .bus_stall (ep_request_stall),
    .bus_error (ep_error),
    .bus_en    (ep_wen),
    .bus_addr  (ep_addr),
    .ack       (ep_ack),
    .fault     (ep_fault)
  );

  // The endpoint port only ever writes full words.
  always_comb begin
    ep_ren    = 1'b0;
    ep_wdata  = ep_req_data;
    ep_strobe = ep_req ? 4'hF : 4'h0;
  end

endmodule

// File: tb/tb_endpoint_tx_dma.sv
// Scoreboard bench for endpoint_tx_dma: expected endpoint writes are queued when
// a command is issued and popped as the DUT completes each write.
`timescale 1ns/1ps
module tb_endpoint_tx_dma;

`ifdef TX_DMA_AUTOSEND_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 1;
`endif

  localparam int MODE_OK     = 0;
  localparam int MODE_REJECT = 1;
  localparam int MODE_PTRERR = 2;
  localparam int MODE_RESET  = 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [8:0]  cmd_offset = '0;
  logic [1:0]  cmd_msg_id = '0;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_request_stall;
  logic        ep_wen;
  logic        ep_ren;
  logic [31:0] ep_addr;
  logic [31:0] ep_wdata;
  logic [3:0]  ep_strobe;
  logic        ep_error;
  logic        ep_request_stall;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic        mon_en = 1'b0;

  int          ep_stall_total = 0;
  int          mem_stall_total = 0;
  int          traffic_total = 0;
  int          ep_stall_end = 0;
  int          mem_stall_end = 0;
  logic [31:0] ep_stall_addr = '0;
  logic [31:0] mem_stall_addr = '0;
  logic [31:0] err_addr = '0;
  logic        err_en = 1'b0;

  endpoint_tx_dma #(.NUM_MSGS(4), .CACHE_NUM_WORDS(128)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_src_addr      (cmd_src_addr),
    .cmd_len           (cmd_len),
    .cmd_offset        (cmd_offset),
    .cmd_msg_id        (cmd_msg_id),
    .mem_ren           (mem_ren),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .mem_request_stall (mem_request_stall),
    .ep_wen            (ep_wen),
    .ep_ren            (ep_ren),
    .ep_addr           (ep_addr),
    .ep_wdata          (ep_wdata),
    .ep_strobe         (ep_strobe),
    .ep_error          (ep_error),
    .ep_request_stall  (ep_request_stall),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  // Host memory content is a fixed function of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign mem_rdata         = mem_model(mem_addr);
  assign mem_request_stall = mem_ren && (mem_addr == mem_stall_addr) && (mem_stall_total < mem_stall_end);
  assign ep_request_stall  = ep_wen && (ep_addr == ep_stall_addr) && (ep_stall_total < ep_stall_end);
  assign ep_error          = err_en && ep_wen && (ep_addr == err_addr);

  // Free-running counters of stalled cycles and bus activity.
  always @(posedge clk) begin
    if (ep_request_stall) ep_stall_total <= ep_stall_total + 1;
    if (mem_request_stall) mem_stall_total <= mem_stall_total + 1;
    if (mem_ren || ep_wen) traffic_total <= traffic_total + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Port rules every cycle, and scoreboard pop on each completed endpoint write.
  always @(negedge clk) begin
    wr_t exp_wr;
    if (mon_en) begin
      checkOutput("ep_ren_low", 32'(ep_ren), 32'd0);
      checkOutput("port_exclusive", 32'(mem_ren & ep_wen), 32'd0);
      if (ep_wen && !ep_request_stall) begin
        checkOutput("ep_strobe", 32'(ep_strobe), 32'hF);
        checkOutput("write_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_wr = sb_q.pop_front();
          checkOutput("wr_addr", ep_addr, exp_wr.addr);
          checkOutput("wr_data", ep_wdata, exp_wr.data);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [31:0] src, input logic [7:0] len,
                               input logic [8:0] off, input logic [1:0] id, input int mode,
                               input int exp_cycles, input int rst_at);
    logic [31:0] src_a;
    logic [31:0] off_a;
    int          ncache;
    int          cycles;
    int          guard;
    int          traffic0;
    bit          finished;
    src_a = {src[31:2], 2'b00};
    off_a = {23'b0, off[8:2], 2'b00};
    if (mode == MODE_REJECT) ncache = 0;
    else if (mode == MODE_RESET) ncache = (rst_at - 1) / 2;
    else ncache = int'(len);
    for (int i = 0; i < ncache; i++) begin
      sb_q.push_back({32'h2000 + off_a + 32'(4 * i), mem_model(src_a + 32'(4 * i))});
    end
    if (mode == MODE_OK || mode == MODE_PTRERR) sb_q.push_back({32'({id, 2'b00}), off_a});
`ifdef TX_DMA_AUTOSEND_EN
    if (mode == MODE_OK) sb_q.push_back({32'h1004, 32'(id)});
`endif
    traffic0 = traffic_total;

    @(negedge clk);
    cmd_src_addr = src;
    cmd_len      = len;
    cmd_offset   = off;
    cmd_msg_id   = id;
    cmd_valid    = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, ":cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    cycles = 0;
    finished = 1'b0;
    while (!finished && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (mode == MODE_RESET && cycles == rst_at) begin
        checkOutput({name, ":rd_word2"}, mem_addr, src_a + 32'd8);
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput({name, ":rst_mem_ren"}, 32'(mem_ren), 32'd0);
        checkOutput({name, ":rst_ep_wen"}, 32'(ep_wen), 32'd0);
        checkOutput({name, ":rst_busy"}, 32'(busy), 32'd0);
        checkOutput({name, ":rst_done_err"}, 32'({done, err}), 32'd0);
        checkOutput({name, ":rst_cmd_ready"}, 32'(cmd_ready), 32'd0);
        n_rst = 1'b0;
        @(negedge clk);
        checkOutput({name, ":post_rst_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({name, ":sb_empty"}, 32'(sb_q.size()), 32'd0);
        finished = 1'b1;
      end else if (done || err) begin
        finished = 1'b1;
        checkOutput({name, ":latency"}, 32'(cycles), 32'(exp_cycles));
        checkOutput({name, ":done"}, 32'(done), 32'(mode == MODE_OK));
        checkOutput({name, ":err"}, 32'(err), 32'(mode != MODE_OK));
        checkOutput({name, ":sb_empty"}, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        checkOutput({name, ":pulse_one"}, 32'({done, err}), 32'd0);
        checkOutput({name, ":busy_after"}, 32'(busy), 32'd0);
        if (mode == MODE_REJECT) begin
          checkOutput({name, ":no_traffic"}, 32'(traffic_total - traffic0), 32'd0);
        end
      end
    end
    if (!finished) begin
      checkOutput({name, ":timeout"}, 32'(cycles), 32'(exp_cycles));
    end
    sb_q.delete();
  endtask

  initial begin
    int stall0;
    n_rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_strobes", 32'({mem_ren, ep_wen, done, err}), 32'd0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

    applyStimulus("basic", 32'h100, 8'd4, 9'h040, 2'd2, MODE_OK, 1 + 8 + TAIL, 0);

    stall0 = ep_stall_total;
    ep_stall_addr = 32'h2044;
    ep_stall_end  = ep_stall_total + 3;
    applyStimulus("ep_stall", 32'h100, 8'd4, 9'h040, 2'd2, MODE_OK, 1 + 8 + TAIL + 3, 0);
    checkOutput("ep_stall_applied", 32'(ep_stall_total - stall0), 32'd3);

    stall0 = mem_stall_total;
    mem_stall_addr = 32'h108;
    mem_stall_end  = mem_stall_total + 2;
    applyStimulus("mem_stall", 32'h100, 8'd4, 9'h040, 2'd2, MODE_OK, 1 + 8 + TAIL + 2, 0);
    checkOutput("mem_stall_applied", 32'(mem_stall_total - stall0), 32'd2);

    applyStimulus("len_zero", 32'h100, 8'd0, 9'h040, 2'd1, MODE_REJECT, 1, 0);
    applyStimulus("overflow", 32'h100, 8'd8, 9'h1F0, 2'd1, MODE_REJECT, 1, 0);
    applyStimulus("edge_fit", 32'h400, 8'd4, 9'h1F0, 2'd3, MODE_OK, 1 + 8 + TAIL, 0);
    applyStimulus("misalign", 32'h203, 8'd2, 9'h043, 2'd1, MODE_OK, 1 + 4 + TAIL, 0);

    err_addr = 32'h8;
    err_en   = 1'b1;
    applyStimulus("ptr_error", 32'h300, 8'd2, 9'h010, 2'd2, MODE_PTRERR, 6, 0);
    err_en   = 1'b0;

    applyStimulus("mid_reset", 32'h100, 8'd4, 9'h040, 2'd2, MODE_RESET, 0, 5);
    applyStimulus("after_rst", 32'h600, 8'd3, 9'h020, 2'd0, MODE_OK, 1 + 6 + TAIL, 0);
    applyStimulus("len_one", 32'h500, 8'd1, 9'h000, 2'd1, MODE_OK, 1 + 2 + TAIL, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
